push_crc_sequencer: RTL and testbench
=====================================

// Module: push_crc_sequencer
// PURPOSE
//  Sequences one packet onto a byte stream: len_a bytes from source A, then len_b
//  bytes from source B, then a 2-byte CRC-16 over all emitted payload bytes.
//  Sits between the two push sources and the downstream link. Owns the
//  IDLE/PUSH_A/PUSH_B/CRC sequence and the running CRC.
// PARAMETERS
//  LEN_W     8        width of len_a/len_b (max segment = 2**LEN_W-1 bytes)
//  CRC_POLY  16'h1021 CRC-16 polynomial (MSB-first, no reflection, no final XOR)
//  CRC_INIT  16'hFFFF CRC seed loaded at each accepted start
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rstn       in   1      asynchronous active-low reset
//  start      in   1      begin packet; sampled only in IDLE
//  len_a      in   LEN_W  segment A byte count, latched at start
//  len_b      in   LEN_W  segment B byte count, latched at start
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse after last CRC byte handshake
//  a_data     in   8      source A byte
//  a_valid    in   1      source A byte available
//  a_ready    out  1      source A byte consumed this cycle
//  b_data     in   8      source B byte
//  b_valid    in   1      source B byte available
//  b_ready    out  1      source B byte consumed this cycle
//  out_data   out  8      downstream byte
//  out_valid  out  1      downstream byte valid
//  out_ready  in   1      downstream accepts
//  out_last   out  1      marks final byte (CRC low byte)
// BEHAVIOUR
//  - Reset: state=IDLE, crc=CRC_INIT, counters=0, done=0; comb outputs then give
//    busy/out_valid/out_last/a_ready/b_ready=0. out_data=0 whenever out_valid=0.
//  - Handshake: transfer when out_valid&out_ready. out_valid held until accepted;
//    out_data stable while out_valid&~out_ready.
//  - States: IDLE, PUSH_A, PUSH_B, CRC_HI, CRC_LO.
//  - IDLE: start=1 -> latch lengths, crc<=CRC_INIT; next = PUSH_A if len_a!=0,
//    else PUSH_B if len_b!=0, else CRC_HI. start while busy ignored.
//  - PUSH_A: zero-latency pass-through: out_data=a_data, out_valid=a_valid,
//    a_ready=out_ready. Each transfer: crc<=crc_step(crc,a_data), cnt+1; on
//    len_a-th transfer -> PUSH_B (len_b!=0) or CRC_HI. b_ready=0.
//  - PUSH_B: same using B ports; a_ready=0; on len_b-th transfer -> CRC_HI.
//  - CRC_HI: out_data=crc[15:8], out_valid=1; crc frozen; transfer -> CRC_LO.
//  - CRC_LO: out_data=crc[7:0], out_valid=1, out_last=1; transfer -> IDLE, done=1
//    next cycle (state already IDLE). start in the done cycle is accepted.
//  - crc_step: 8 iterations MSB-first: fb=crc[15]^d[7-i]; crc={crc[14:0],0}^
//    (fb?CRC_POLY:0). Combinational, one byte per cycle.
//  - a_ready/b_ready never high outside their own state; bytes of an idle
//    source never consumed.
//  - Counter is LEN_W bits; no wrap possible since compare is against latched len.
//  - Reset mid-packet: immediate return to IDLE, no done, partial packet dropped
//    (no out_last emitted).
// TESTING
//  - len_a=4 "1234", len_b=5 "56789", out_ready=1 -> bytes 31..39,29,B1; out_last
//    on B1 only; done 1 cycle after; 11 handshakes.
//  - Same packet, out_ready toggled 1/0 each cycle -> identical byte sequence;
//    out_data stable while stalled; a/b_ready never 1 when out_ready=0.
//  - len_a=0,len_b=0 -> CRC_HI/CRC_LO emit FF,FF (seed); a_ready,b_ready stay 0.
//  - len_a=0,len_b=1 byte 00 -> emits 00,E1,F0; A bytes untouched.
//  - start pulsed during PUSH_B -> ignored, lengths/crc unchanged; start in done
//    cycle -> new packet begins next cycle with crc=FFFF.
//  - rstn low during PUSH_A after 2 bytes -> busy=0,out_valid=0 asynchronously;
//    no done; next start yields correct CRC from seed.

Source files
------------

// File: rtl/push_crc_sequencer.sv
// push_crc_sequencer
// Emits one packet onto a byte stream: len_a bytes passed through from source A,
// then len_b bytes from source B, then the CRC-16 of those payload bytes (high
// byte first). Payload bytes pass through combinationally; the CRC is updated
// one byte per accepted transfer.
//
// state  | meaning
// IDLE   | waiting for start; lengths and CRC seed are loaded on start
// PUSH_A | forwarding source A bytes until len_a transfers have completed
// PUSH_B | forwarding source B bytes until len_b transfers have completed
// CRC_HI | presenting crc[15:8]; the CRC is frozen from here on
// CRC_LO | presenting crc[7:0] with out_last; done pulses after it is accepted
module push_crc_sequencer #(
    parameter int          LEN_W    = 8,
    parameter logic [15:0] CRC_POLY = 16'h1021,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len_a,
    input  logic [LEN_W-1:0] len_b,
    output logic             busy,
    output logic             done,
    input  logic [7:0]       a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [7:0]       b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH_A = 3'd1,
        PUSH_B = 3'd2,
        CRC_HI = 3'd3,
        CRC_LO = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      crc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_a_q;
    logic [LEN_W-1:0] len_b_q;
    logic             xfer;

    // Bitwise MSB-first CRC update over one byte, unrolled into combinational logic.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[7-i];
            r  = {r[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return r;
    endfunction

    assign cnt_inc = cnt + {{(LEN_W-1){1'b0}}, 1'b1};
    assign xfer    = out_valid & out_ready;
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and stream muxing; out_data is forced to zero whenever no byte is offered.
    always_comb begin
        state_next = state;
        out_data   = 8'h00;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_a != '0)      state_next = PUSH_A;
                    else if (len_b != '0) state_next = PUSH_B;
                    else                  state_next = CRC_HI;
                end
            end
            PUSH_A: begin
                out_valid = a_valid;
                out_data  = a_valid ? a_data : 8'h00;
                a_ready   = out_ready;
                if (a_valid && out_ready && (cnt_inc == len_a_q)) begin
                    state_next = (len_b_q != '0) ? PUSH_B : CRC_HI;
                end
            end
            PUSH_B: begin
                out_valid = b_valid;
                out_data  = b_valid ? b_data : 8'h00;
                b_ready   = out_ready;
                if (b_valid && out_ready && (cnt_inc == len_b_q)) begin
                    state_next = CRC_HI;
                end
            end
            CRC_HI: begin
                out_valid = 1'b1;
                out_data  = crc[15:8];
                if (out_ready) state_next = CRC_LO;
            end
            CRC_LO: begin
                out_valid = 1'b1;
                out_data  = crc[7:0];
                out_last  = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Length latch, running CRC and per-segment byte counter; counter clears at each segment end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc     <= CRC_INIT;
            cnt     <= '0;
            len_a_q <= '0;
            len_b_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_a_q <= len_a;
                        len_b_q <= len_b;
                        crc     <= CRC_INIT;
                        cnt     <= '0;
                    end
                end
                PUSH_A: begin
                    if (xfer) begin
                        crc <= crc_step(crc, a_data);
                        cnt <= (cnt_inc == len_a_q) ? '0 : cnt_inc;
                    end
                end
                PUSH_B: begin
                    if (xfer) begin
                        crc <= crc_step(crc, b_data);
                        cnt <= (cnt_inc == len_b_q) ? '0 : cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulse, one cycle after the CRC low byte is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done <= 1'b0;
        end else begin
            done <= (state == CRC_LO) && xfer;
        end
    end

endmodule

// File: tb/tb_push_crc_sequencer.sv
// Directed bench for push_crc_sequencer: packet contents, backpressure,
// empty segments, start filtering and mid-packet reset.
module tb_push_crc_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] len_a, len_b;
    logic       busy, done;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] src_a [16];
    logic [7:0] src_b [16];
    int         a_avail, b_avail;

    logic [7:0] got_q [$];
    int         stall_err, rdy_err, last_cnt, last_pos;
    int         a_used, b_used, a_rdy_seen, b_rdy_seen;
    bit         done_ok, timed_out;

    logic [7:0] exp_full [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                  8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    logic [7:0] exp_bonly [3] = '{8'h00, 8'hE1, 8'hF0};

    push_crc_sequencer dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .len_a     (len_a),
        .len_b     (len_b),
        .busy      (busy),
        .done      (done),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic load_full_sources();
        for (int i = 0; i < 4; i++) src_a[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 5; i++) src_b[i] = 8'h35 + 8'(i);
        a_avail = 4;
        b_avail = 5;
    endtask

    // Starts a packet and runs the source/sink models until nexp bytes are accepted.
    task automatic drive_packet(input int la, input int lb, input bit toggle, input int nexp,
                                input int glitch_cyc, input bit start_now);
        int         pa, pb, cyc;
        bit         stalled;
        logic [7:0] held;
        got_q.delete();
        stall_err = 0; rdy_err = 0; last_cnt = 0; last_pos = -1;
        a_rdy_seen = 0; b_rdy_seen = 0; done_ok = 0; timed_out = 0;
        pa = 0; pb = 0; stalled = 0; held = 8'h00;
        if (!start_now) begin
            @(posedge clk); #1;
        end
        start = 1'b1; len_a = 8'(la); len_b = 8'(lb);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (got_q.size() < nexp && cyc < 300) begin
            if (cyc == glitch_cyc) begin
                start = 1'b1; len_a = 8'd7; len_b = 8'd7;
            end else begin
                start = 1'b0; len_a = 8'(la); len_b = 8'(lb);
            end
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            a_valid   = (pa < a_avail);
            a_data    = (pa < a_avail) ? src_a[pa] : 8'h00;
            b_valid   = (pb < b_avail);
            b_data    = (pb < b_avail) ? src_b[pb] : 8'h00;
            #1;
            if (stalled && out_data !== held) stall_err++;
            if (!out_ready && (a_ready || b_ready)) rdy_err++;
            if (a_ready) a_rdy_seen++;
            if (b_ready) b_rdy_seen++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (out_last) begin
                    last_cnt++;
                    last_pos = got_q.size() - 1;
                end
                stalled = 0;
            end else if (out_valid) begin
                stalled = 1;
                held    = out_data;
            end else begin
                stalled = 0;
            end
            if (a_valid && a_ready) pa++;
            if (b_valid && b_ready) pb++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; len_a = 8'(la); len_b = 8'(lb);
        timed_out = (got_q.size() < nexp);
        done_ok   = (done === 1'b1) && (busy === 1'b0);
        a_used = pa;
        b_used = pb;
        out_ready = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b1; b_data = 8'hA5; out_ready = 1'b1;
        #1;
        total_cnt++;
        if ({busy, out_valid, out_last, a_ready, b_ready, done} !== 6'b0) begin
            $display("FAIL reset_ctrl: got busy/ov/last/ar/br/done=%b required 000000",
                     {busy, out_valid, out_last, a_ready, b_ready, done});
        end else pass_cnt++;
        total_cnt++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h required 00", out_data);
        else pass_cnt++;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    endtask

    task automatic check_full_packet(input string tag);
        for (int i = 0; i < 11; i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_full[i]) $display("FAIL %s_byte%0d: got %h required %h", tag, i, g, exp_full[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (timed_out) $display("FAIL %s_timeout: got %0d bytes required 11", tag, got_q.size());
        else pass_cnt++;
    endtask

    task automatic test_basic();
        load_full_sources();
        drive_packet(4, 5, 1'b0, 11, -1, 1'b0);
        check_full_packet("basic");
        total_cnt++;
        if (last_cnt !== 1 || last_pos !== 10)
            $display("FAIL basic_last: got count %0d pos %0d required count 1 pos 10", last_cnt, last_pos);
        else pass_cnt++;
        total_cnt++;
        if (!done_ok) $display("FAIL basic_done: got done=%b busy=%b required done=1 busy=0", done, busy);
        else pass_cnt++;
        total_cnt++;
        if (a_used !== 4 || b_used !== 5)
            $display("FAIL basic_consumed: got a=%0d b=%0d required a=4 b=5", a_used, b_used);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse: got done=%b required 0", done);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        load_full_sources();
        drive_packet(4, 5, 1'b1, 11, -1, 1'b0);
        check_full_packet("stall");
        total_cnt++;
        if (stall_err !== 0) $display("FAIL stall_stable: got %0d changes required 0", stall_err);
        else pass_cnt++;
        total_cnt++;
        if (rdy_err !== 0) $display("FAIL stall_ready: got %0d ready-while-stalled required 0", rdy_err);
        else pass_cnt++;
        total_cnt++;
        if (!done_ok) $display("FAIL stall_done: got done=%b required 1", done);
        else pass_cnt++;
    endtask

    task automatic test_empty();
        load_full_sources();
        drive_packet(0, 0, 1'b0, 2, -1, 1'b0);
        total_cnt++;
        if (got_q.size() !== 2 || got_q[0] !== 8'hFF || got_q[1] !== 8'hFF)
            $display("FAIL empty_crc: got %0d bytes first %h required FF,FF", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx);
        else pass_cnt++;
        total_cnt++;
        if (a_rdy_seen !== 0 || b_rdy_seen !== 0 || a_used !== 0 || b_used !== 0)
            $display("FAIL empty_ready: got a_ready %0d b_ready %0d cycles required 0", a_rdy_seen, b_rdy_seen);
        else pass_cnt++;
        total_cnt++;
        if (last_pos !== 1 || !done_ok)
            $display("FAIL empty_last_done: got last_pos %0d done %b required 1 and 1", last_pos, done);
        else pass_cnt++;
    endtask

    task automatic check_bonly(input string tag);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_bonly[i]) $display("FAIL %s_byte%0d: got %h required %h", tag, i, g, exp_bonly[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (a_used !== 0 || a_rdy_seen !== 0)
            $display("FAIL %s_a_untouched: got used %0d ready %0d required 0", tag, a_used, a_rdy_seen);
        else pass_cnt++;
    endtask

    task automatic test_b_only();
        load_full_sources();
        src_b[0] = 8'h00;
        b_avail  = 1;
        drive_packet(0, 1, 1'b0, 3, -1, 1'b0);
        check_bonly("bonly");
    endtask

    task automatic test_start_filter();
        load_full_sources();
        drive_packet(4, 5, 1'b0, 11, 6, 1'b0);
        check_full_packet("glitch");
        total_cnt++;
        if (!done_ok) $display("FAIL glitch_done: got done=%b required 1", done);
        else pass_cnt++;
        load_full_sources();
        src_b[0] = 8'h00;
        b_avail  = 1;
        drive_packet(0, 1, 1'b0, 3, -1, 1'b1);
        check_bonly("restart");
    endtask

    task automatic test_reset_mid();
        load_full_sources();
        drive_packet(4, 5, 1'b0, 2, -1, 1'b0);
        a_valid = 1'b1; a_data = src_a[2]; out_ready = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rstmid_async: got busy=%b out_valid=%b required 0 0", busy, out_valid);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (done !== 1'b0 || out_last !== 1'b0)
                $display("FAIL rstmid_no_done: got done=%b out_last=%b required 0 0", done, out_last);
            else pass_cnt++;
        end
        #2 rstn = 1'b1;
        a_valid = 1'b0;
        load_full_sources();
        drive_packet(4, 5, 1'b0, 11, -1, 1'b0);
        check_full_packet("after_rst");
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; len_a = 8'd0; len_b = 8'd0;
        a_data = 8'h00; a_valid = 1'b0; b_data = 8'h00; b_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        test_basic();
        test_backpressure();
        test_empty();
        test_b_only();
        test_start_filter();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
